// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer and its datapath: state encoding
// and the default width of the element counter / length fields.
`timescale 1ns/1ps
package mac_sequencer_pkg;

  localparam int CNT_W_DEF = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_MUL   = 3'd3;
  localparam logic [2:0] ST_ACC   = 3'd4;
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [2:0] ST_OUT   = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_CLR   = ST_CLR,
    S_LOAD  = ST_LOAD,
    S_MUL   = ST_MUL,
    S_ACC   = ST_ACC,
    S_CHECK = ST_CHECK,
    S_OUT   = ST_OUT,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/mac_sequencer.sv
// Control sequencer for a multiply-accumulate datapath: loads operand pairs,
// multiplies, accumulates and publishes the sum after len elements (or on CMP).
`timescale 1ns/1ps
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter bit FIXED_LEN_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_abort,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_cmp,
  input  logic [CNT_W-1:0] i_count_out,
  output logic             o_ld_a,
  output logic             o_ld_b,
  output logic             o_ld_m,
  output logic             o_ld_acc,
  output logic             o_ld_out,
  output logic             o_count_enb,
  output logic             o_count_reset,
  output logic             o_acc_clr,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_len;
  logic             r_aborted;
  logic             w_abortNow;
  logic             w_terminal;

  assign w_abortNow = i_abort && (r_state != S_IDLE);

  // A zero length hands termination over to the datapath comparator when enabled.
  assign w_terminal = (r_len != '0) ? (i_count_out == r_len)
                                    : (FIXED_LEN_EN && i_cmp);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_aborted <= w_abortNow;
      if (r_state == S_IDLE && i_start) begin
        r_len <= i_len;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    o_in_ready    = 1'b0;
    o_ld_a        = 1'b0;
    o_ld_b        = 1'b0;
    o_ld_m        = 1'b0;
    o_ld_acc      = 1'b0;
    o_ld_out      = 1'b0;
    o_count_enb   = 1'b0;
    o_count_reset = 1'b0;
    o_acc_clr     = 1'b0;
    o_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_CLR;
      end
      S_CLR: begin
        o_count_reset = 1'b1;
        o_acc_clr     = 1'b1;
        w_next        = (r_len == '0 && !FIXED_LEN_EN) ? S_OUT : S_LOAD;
      end
      S_LOAD: begin
        o_in_ready = 1'b1;
        o_ld_a     = i_in_valid;
        o_ld_b     = i_in_valid;
        if (i_in_valid) w_next = S_MUL;
      end
      S_MUL: begin
        o_ld_m = 1'b1;
        w_next = S_ACC;
      end
      S_ACC: begin
        o_ld_acc    = 1'b1;
        o_count_enb = 1'b1;
        w_next      = S_CHECK;
      end
      S_CHECK: begin
        w_next = w_terminal ? S_OUT : S_LOAD;
      end
      S_OUT: begin
        o_ld_out = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // Abort wins over everything and leaves the datapath untouched this cycle.
    if (w_abortNow) begin
      w_next        = S_IDLE;
      o_in_ready    = 1'b0;
      o_ld_a        = 1'b0;
      o_ld_b        = 1'b0;
      o_ld_m        = 1'b0;
      o_ld_acc      = 1'b0;
      o_ld_out      = 1'b0;
      o_count_enb   = 1'b0;
      o_count_reset = 1'b0;
      o_acc_clr     = 1'b0;
      o_done        = 1'b0;
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_aborted = r_aborted;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: a behavioural datapath plus a
// sum/latency reference model computed directly from the operand lists.
`timescale 1ns/1ps
module tb_mac_sequencer;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rstN;
  logic start, abortIn, inValid;
  logic [CNT_W-1:0] lenIn;
  logic inReady, ldA, ldB, ldM, ldAcc, ldOut, countEnb, countReset, accClr;
  logic busy, done, aborted;
  logic d0InReady, d0LdA, d0LdB, d0LdM, d0LdAcc, d0LdOut, d0CountEnb;
  logic d0CountReset, d0AccClr, d0Busy, d0Done, d0Aborted;

  logic [7:0]       opsA [16];
  logic [7:0]       opsB [16];
  logic [7:0]       opA, opB;
  logic [7:0]       dpA, dpB;
  logic [15:0]      dpM;
  logic [31:0]      dpAcc, dpSum;
  logic [CNT_W-1:0] dpCnt;
  logic [CNT_W-1:0] cmpTarget;
  logic             cmpIn;
  int               opIdx;
  int               checks = 0;
  int               errors = 0;

  wire [11:0] allOut = {inReady, ldA, ldB, ldM, ldAcc, ldOut, countEnb,
                        countReset, accClr, busy, done, aborted};

  always #5 clk = ~clk;

  assign cmpIn = (dpCnt == cmpTarget);

  always_ff @(posedge clk) begin
    if (ldA) dpA <= opA;
    if (ldB) dpB <= opB;
    if (ldM) dpM <= 16'(dpA) * 16'(dpB);
    if (accClr) dpAcc <= '0;
    else if (ldAcc) dpAcc <= dpAcc + 32'(dpM);
    if (ldOut) dpSum <= dpAcc;
    if (countReset) dpCnt <= '0;
    else if (countEnb) dpCnt <= dpCnt + 1'b1;
  end

  mac_sequencer #(.CNT_W(CNT_W), .FIXED_LEN_EN(1'b1)) u_dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_len(lenIn),
    .i_abort(abortIn), .i_in_valid(inValid), .o_in_ready(inReady),
    .i_cmp(cmpIn), .i_count_out(dpCnt),
    .o_ld_a(ldA), .o_ld_b(ldB), .o_ld_m(ldM), .o_ld_acc(ldAcc), .o_ld_out(ldOut),
    .o_count_enb(countEnb), .o_count_reset(countReset), .o_acc_clr(accClr),
    .o_busy(busy), .o_done(done), .o_aborted(aborted)
  );

  // Second instance exercises the zero-length-completes-immediately variant.
  mac_sequencer #(.CNT_W(CNT_W), .FIXED_LEN_EN(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_len(lenIn),
    .i_abort(abortIn), .i_in_valid(inValid), .o_in_ready(d0InReady),
    .i_cmp(cmpIn), .i_count_out(dpCnt),
    .o_ld_a(d0LdA), .o_ld_b(d0LdB), .o_ld_m(d0LdM), .o_ld_acc(d0LdAcc), .o_ld_out(d0LdOut),
    .o_count_enb(d0CountEnb), .o_count_reset(d0CountReset), .o_acc_clr(d0AccClr),
    .o_busy(d0Busy), .o_done(d0Done), .o_aborted(d0Aborted)
  );

  function automatic logic [31:0] refSum(input int n);
    logic [31:0] s = '0;
    for (int i = 0; i < n; i++) s += 32'(opsA[i]) * 32'(opsB[i]);
    return s;
  endfunction

  task automatic randomOps();
    for (int i = 0; i < 16; i++) begin
      opsA[i] = 8'($urandom_range(0, 255));
      opsB[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // Drives one run; cycle 0 is the IDLE cycle in which start is presented.
  task automatic runJob(input int len, input int stall, output int doneCyc,
                        output int ldOutCnt, output int accCnt, output int stallLd,
                        output int stallReady, output int d0DoneCyc);
    int  cyc;
    int  stallLeft;
    bit  lastLdA;
    stallLeft = stall; doneCyc = -1; ldOutCnt = 0; accCnt = 0;
    stallLd = 0; stallReady = 0; d0DoneCyc = -1; lastLdA = 0; opIdx = 0;
    @(negedge clk);
    start = 1'b1; lenIn = CNT_W'(len); inValid = (stall == 0);
    opA = opsA[0]; opB = opsB[0]; cyc = 0;
    while (doneCyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++; start = 1'b0;
      if (lastLdA) opIdx++;
      opA = opsA[opIdx[3:0]]; opB = opsB[opIdx[3:0]];
      if (inReady && stallLeft > 0) begin
        inValid = 1'b0; stallLeft--; #1;
        stallReady++;
        if (ldA || ldB) stallLd++;
      end else begin
        inValid = 1'b1; #1;
      end
      lastLdA = ldA;
      if (ldOut) ldOutCnt++;
      if (ldAcc) accCnt++;
      if (d0Done && d0DoneCyc < 0) d0DoneCyc = cyc;
      if (done) doneCyc = cyc;
    end
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; start = 1'b1; abortIn = 1'b0; inValid = 1'b1; lenIn = 4'd3;
    cmpTarget = 4'd5; opA = '0; opB = '0;
    #23;
    checks++;
    if (allOut !== 12'h000) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b expected %b", allOut, 12'h000);
    end
    @(negedge clk); start = 1'b0; rstN = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int dc, lo, ac, sl, sr, d0;
    opsA[0] = 8'd2; opsB[0] = 8'd3;
    opsA[1] = 8'd4; opsB[1] = 8'd5;
    opsA[2] = 8'd1; opsB[2] = 8'd1;
    runJob(3, 0, dc, lo, ac, sl, sr, d0);
    checks++;
    if (dc !== 15) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected 15", dc); end
    checks++;
    if (dpSum !== 32'd27) begin errors++; $display("[TB] FAIL basic_sum: got %0d expected 27", dpSum); end
    checks++;
    if (lo !== 1) begin errors++; $display("[TB] FAIL basic_ld_out_count: got %0d expected 1", lo); end
    checks++;
    if (ac !== 3) begin errors++; $display("[TB] FAIL basic_acc_count: got %0d expected 3", ac); end
  endtask

  task automatic test_stall();
    int dc, lo, ac, sl, sr, d0;
    randomOps();
    runJob(2, 5, dc, lo, ac, sl, sr, d0);
    checks++;
    if (dc !== 3 + 4 * 2 + 5) begin errors++; $display("[TB] FAIL stall_done_cycle: got %0d expected %0d", dc, 3 + 4 * 2 + 5); end
    checks++;
    if (sr !== 5) begin errors++; $display("[TB] FAIL stall_ready_held: got %0d expected 5", sr); end
    checks++;
    if (sl !== 0) begin errors++; $display("[TB] FAIL stall_no_load: got %0d expected 0", sl); end
    checks++;
    if (dpSum !== refSum(2)) begin errors++; $display("[TB] FAIL stall_sum: got %0d expected %0d", dpSum, refSum(2)); end
  endtask

  task automatic test_random();
    int dc, lo, ac, sl, sr, d0, len, stall;
    for (int it = 0; it < 5; it++) begin
      randomOps();
      len   = $urandom_range(1, 6);
      stall = $urandom_range(0, 3);
      runJob(len, stall, dc, lo, ac, sl, sr, d0);
      checks++;
      if (dc !== 3 + 4 * len + stall) begin
        errors++; $display("[TB] FAIL rand_done_cycle: len=%0d stall=%0d got %0d expected %0d", len, stall, dc, 3 + 4 * len + stall);
      end
      checks++;
      if (dpSum !== refSum(len)) begin
        errors++; $display("[TB] FAIL rand_sum: len=%0d got %0d expected %0d", len, dpSum, refSum(len));
      end
    end
  endtask

  task automatic test_cmp_mode();
    int dc, lo, ac, sl, sr, d0;
    randomOps();
    cmpTarget = 4'd5;
    runJob(0, 0, dc, lo, ac, sl, sr, d0);
    checks++;
    if (ac !== 5) begin errors++; $display("[TB] FAIL cmp_acc_count: got %0d expected 5", ac); end
    checks++;
    if (dc !== 3 + 4 * 5) begin errors++; $display("[TB] FAIL cmp_done_cycle: got %0d expected %0d", dc, 3 + 4 * 5); end
    checks++;
    if (dpSum !== refSum(5)) begin errors++; $display("[TB] FAIL cmp_sum: got %0d expected %0d", dpSum, refSum(5)); end
    checks++;
    if (d0 !== 3) begin errors++; $display("[TB] FAIL zero_len_done_cycle: got %0d expected 3", d0); end
  endtask

  task automatic test_abort();
    logic [31:0] sumBefore;
    int doneSeen;
    sumBefore = dpSum; doneSeen = 0;
    opA = 8'd7; opB = 8'd9;
    @(negedge clk); start = 1'b1; lenIn = 4'd4; inValid = 1'b1;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk); start = 1'b0; #1;
      if (done) doneSeen++;
    end
    @(negedge clk); #1;
    checks++;
    if (ldAcc !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_acc_state: got %b expected 1", ldAcc); end
    abortIn = 1'b1; #1;
    checks++;
    if ({ldAcc, countEnb, ldM, ldOut} !== 4'b0000 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_cycle_ctrl: got ld/cnt=%b busy=%b expected 0000 busy=1", {ldAcc, countEnb, ldM, ldOut}, busy);
    end
    @(negedge clk); abortIn = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_next_cycle: got busy=%b aborted=%b expected busy=0 aborted=1", busy, aborted);
    end
    @(negedge clk); #1;
    checks++;
    if (aborted !== 1'b0) begin errors++; $display("[TB] FAIL abort_pulse_width: got %b expected 0", aborted); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (done) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", doneSeen); end
    checks++;
    if (dpSum !== sumBefore) begin errors++; $display("[TB] FAIL abort_sum_kept: got %0d expected %0d", dpSum, sumBefore); end
    // Abort must beat an operand accept in LOAD.
    @(negedge clk); start = 1'b1; lenIn = 4'd1; inValid = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); inValid = 1'b1; abortIn = 1'b1; #1;
    checks++;
    if (ldA !== 1'b0 || inReady !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_load_priority: got ld_a=%b in_ready=%b expected 0 0", ldA, inReady);
    end
    @(negedge clk); abortIn = 1'b0; inValid = 1'b0; #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_load_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_mid_reset();
    int dc, lo, ac, sl, sr, d0, pulses;
    opA = 8'd5; opB = 8'd6; pulses = 0;
    @(negedge clk); start = 1'b1; lenIn = 4'd2; inValid = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (ldM !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_mul: got %b expected 1", ldM); end
    #1 rstN = 1'b0; #1;
    checks++;
    if (allOut !== 12'h000) begin errors++; $display("[TB] FAIL midreset_async_outputs: got %b expected %b", allOut, 12'h000); end
    @(negedge clk); rstN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (done || aborted || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("[TB] FAIL midreset_no_pulse: got %0d expected 0", pulses); end
    opsA[0] = 8'd3; opsB[0] = 8'd3;
    runJob(1, 0, dc, lo, ac, sl, sr, d0);
    checks++;
    if (dpSum !== 32'd9 || dc !== 7) begin
      errors++; $display("[TB] FAIL midreset_rerun: got sum=%0d done=%0d expected sum=9 done=7", dpSum, dc);
    end
  endtask

  task automatic test_start_ignored();
    int doneCnt, doneCyc, busyAfter;
    doneCnt = 0; doneCyc = -1; busyAfter = -1;
    opA = 8'd2; opB = 8'd2;
    @(negedge clk); start = 1'b1; lenIn = 4'd1; inValid = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 7);
      #1;
      if (done) begin doneCnt++; doneCyc = c; end
      if (c == 8) busyAfter = busy;
    end
    start = 1'b0;
    checks++;
    if (doneCnt !== 1 || doneCyc !== 7) begin
      errors++; $display("[TB] FAIL start_ignored_runs: got count=%0d cycle=%0d expected count=1 cycle=7", doneCnt, doneCyc);
    end
    checks++;
    if (busyAfter !== 0) begin errors++; $display("[TB] FAIL start_in_done_ignored: got busy=%0d expected 0", busyAfter); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_cmp_mode();
    test_abort();
    test_mid_reset();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter: CNT_W, 4, width of element count and length fields.
REQ-002 Parameter: FIXED_LEN_EN, 1, 1 = len==0 selects CMP-terminated mode; 0 = len==0 completes with no elements.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 len  input  CNT_W  number of products to accumulate; captured on start.
REQ-007 abort  input  1  cancel run in any non-IDLE state.
REQ-008 in_valid / in_ready  input / output  1 / 1  operand handshake; operand pair on datapath a,b accepted when both high.
REQ-009 CMP  input  1  datapath comparator terminal flag.
REQ-010 count_out  input  CNT_W  datapath counter value.
REQ-011 ld_a, ld_b, ld_m, ld_acc, ld_out, count_enb, count_reset, acc_clr  output  1 each  datapath controls.
REQ-012 busy, done, aborted  output  1 each  status; done/aborted are one-cycle pulses.

Function
REQ-013 States SHALL be IDLE, CLR, LOAD, MUL, ACC, CHECK, OUT, DONE; all outputs Moore-decoded except in_ready/ld_a/ld_b.
REQ-014 IDLE: start=1 -> capture len into len_q, go CLR; start ignored in every other state.
REQ-015 CLR (1 cycle): count_reset=1, acc_clr=1 -> LOAD.
REQ-016 LOAD: in_ready=1; ld_a=ld_b=in_valid; in_valid=1 -> MUL, else remain in LOAD (no timeout).
REQ-017 MUL (1 cycle): ld_m=1 -> ACC.
REQ-018 ACC (1 cycle): ld_acc=1, count_enb=1 -> CHECK.
REQ-019 CHECK: terminal = (count_out == len_q) when len_q!=0, or CMP when len_q==0 and FIXED_LEN_EN=1; terminal -> OUT, else -> LOAD.
REQ-020 len_q==0 with FIXED_LEN_EN=0: CLR -> OUT directly (result = cleared accumulator).
REQ-021 OUT (1 cycle): ld_out=1 -> DONE.
REQ-022 DONE (1 cycle): done=1 -> IDLE; start seen in DONE is ignored.
REQ-023 busy=1 in every state except IDLE.
REQ-024 Per element latency with in_valid held high: 4 cycles (LOAD, MUL, ACC, CHECK); start-to-done = 3 + 4*len cycles.
REQ-025 abort=1 in any non-IDLE state -> IDLE next cycle; that cycle asserts no ld_* / count_enb; aborted=1 for one cycle; done not asserted; sum_out register not updated.
REQ-026 abort takes priority over every other transition, including the CHECK terminal decision and the in_valid accept in LOAD.
REQ-027 Only one of ld_m, ld_acc, ld_out SHALL be high in any cycle.

Reset
REQ-028 rst low: state=IDLE, len_q=0, every output 0 immediately, regardless of clock.
REQ-029 Reset mid-run: no done/aborted pulse; first start after release begins a clean run.

Structure
REQ-030 Shared package holds state encoding (3-bit localparams) and CNT_W default, reused by datapath counter.
REQ-031 Single flat module; no sub-module. The terminal-condition compare is internal.

Verification
REQ-032 len=3, operand pairs (2,3),(4,5),(1,1), in_valid constant high -> done in cycle 15 after start; sum_out=27; ld_out exactly once.
REQ-033 len=2, in_valid low 5 cycles in first LOAD -> in_ready held, no ld_a, done 5 cycles later than nominal, sum_out correct.
REQ-034 abort asserted in second ACC of len=4 run -> IDLE next cycle, aborted pulse, done never high, sum_out unchanged.
REQ-035 len=0, FIXED_LEN_EN=1, CMP high after count_out=5 -> exactly 5 accumulations then OUT/DONE.
REQ-036 rst low during MUL -> all outputs 0 asynchronously; after release start len=1 (3,3) -> sum_out=9.
REQ-037 start pulsed while busy and in DONE -> ignored; exactly one run completes.
